mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : mem_stage
// Desc     : Pipeline memory stage: bus master FSM plus MEM pipeline register.
// Revision : 1.0 - initial release
//==============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wdata,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_wen,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        bus_as,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rdy,
    output logic        busy,
    output logic [31:0] fwd_data,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_wen,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    typedef enum logic [1:0] {
        c_IDLE   = 2'd0,
        c_REQ    = 2'd1,
        c_ACCESS = 2'd2,
        c_WAIT   = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_LOAD      = 2'd1;
    localparam logic [1:0] c_OP_STORE     = 2'd2;
    localparam logic [2:0] c_EXP_MISALIGN = 3'd4;
    localparam logic [2:0] c_EXP_TIMEOUT  = 3'd6;
    localparam logic [9:0] c_CNT_MAX      = 10'h3FF;
    localparam logic [9:0] c_TO_LAST      = 10'(TIMEOUT_CYC - 1);

    state_t      r_state_q, w_state_d;
    logic [9:0]  r_cnt_q, w_cnt_d;
    logic        r_pend_q, w_pend_d;
    logic        r_hold_q, w_hold_d;
    logic [31:0] r_hold_data_q, w_hold_data_d;
    logic        r_hold_to_q, w_hold_to_d;
    logic        r_bus_rw_q, w_bus_rw_d;
    logic [29:0] r_bus_addr_q, w_bus_addr_d;
    logic [31:0] r_bus_wdata_q, w_bus_wdata_d;

    logic [29:0] r_mem_pc_q, w_mem_pc_d;
    logic        r_mem_en_q, w_mem_en_d;
    logic        r_mem_br_flag_q, w_mem_br_flag_d;
    logic [1:0]  r_mem_ctrl_op_q, w_mem_ctrl_op_d;
    logic [4:0]  r_mem_dst_addr_q, w_mem_dst_addr_d;
    logic        r_mem_gpr_wen_q, w_mem_gpr_wen_d;
    logic [2:0]  r_mem_exp_code_q, w_mem_exp_code_d;
    logic [31:0] r_mem_out_q, w_mem_out_d;

    logic        w_mem_req;
    logic        w_aligned;
    logic        w_misalign;
    logic        w_start;
    logic        w_done;
    logic        w_timeout;
    logic        w_finish;
    logic        w_busy;
    logic        w_load_rdata;
    logic        w_res_to;
    logic        w_load;
    logic [31:0] w_fwd;

    // A result parked by stall blocks new starts until it has been loaded.
    always_comb begin
        w_mem_req    = ex_en && (ex_mem_op == c_OP_LOAD || ex_mem_op == c_OP_STORE)
                       && (ex_exp_code == 3'd0);
        w_aligned    = (ex_out[1:0] == 2'b00);
        w_misalign   = w_mem_req && !w_aligned;
        w_start      = (r_state_q == c_IDLE) && !r_hold_q && w_mem_req && w_aligned && !flush;
        w_done       = (r_state_q == c_WAIT) && bus_rdy;
        w_timeout    = (r_state_q == c_WAIT) && !bus_rdy && (r_cnt_q == c_TO_LAST);
        w_finish     = w_done || w_timeout;
        w_busy       = w_start || ((r_state_q != c_IDLE) && !w_finish);
        w_load_rdata = w_done && r_bus_rw_q;
        w_res_to     = r_hold_q ? r_hold_to_q : w_timeout;
        w_load       = !flush && !w_busy && !stall;
        if (r_hold_q) begin
            w_fwd = r_hold_data_q;
        end else if (w_load_rdata) begin
            w_fwd = bus_rdata;
        end else begin
            w_fwd = ex_out;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:   if (w_start)   w_state_d = c_REQ;
            c_REQ:    if (bus_grant) w_state_d = c_ACCESS;
            c_ACCESS:                w_state_d = c_WAIT;
            c_WAIT:   if (w_finish)  w_state_d = c_IDLE;
            default:                 w_state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (r_state_q == c_ACCESS) begin
            w_cnt_d = 10'd0;
        end else if ((r_state_q == c_WAIT) && (r_cnt_q != c_CNT_MAX)) begin
            w_cnt_d = r_cnt_q + 10'd1;
        end

        w_bus_rw_d    = r_bus_rw_q;
        w_bus_addr_d  = r_bus_addr_q;
        w_bus_wdata_d = r_bus_wdata_q;
        if (w_start) begin
            w_bus_rw_d    = (ex_mem_op == c_OP_LOAD);
            w_bus_addr_d  = ex_out[31:2];
            w_bus_wdata_d = ex_mem_wdata;
        end

        // Flush while the bus is busy is remembered until the result lands.
        w_pend_d = r_pend_q;
        if (flush) begin
            w_pend_d = (r_state_q != c_IDLE) && !w_finish;
        end else if (w_load) begin
            w_pend_d = 1'b0;
        end

        w_hold_d      = r_hold_q;
        w_hold_data_d = r_hold_data_q;
        w_hold_to_d   = r_hold_to_q;
        if (flush) begin
            w_hold_d = 1'b0;
        end else if (w_finish && stall) begin
            w_hold_d      = 1'b1;
            w_hold_data_d = w_load_rdata ? bus_rdata : ex_out;
            w_hold_to_d   = w_timeout;
        end else if (w_load) begin
            w_hold_d = 1'b0;
        end
    end

    always_comb begin
        w_mem_pc_d       = r_mem_pc_q;
        w_mem_en_d       = r_mem_en_q;
        w_mem_br_flag_d  = r_mem_br_flag_q;
        w_mem_ctrl_op_d  = r_mem_ctrl_op_q;
        w_mem_dst_addr_d = r_mem_dst_addr_q;
        w_mem_gpr_wen_d  = r_mem_gpr_wen_q;
        w_mem_exp_code_d = r_mem_exp_code_q;
        w_mem_out_d      = r_mem_out_q;
        if (flush) begin
            w_mem_pc_d       = 30'd0;
            w_mem_en_d       = 1'b0;
            w_mem_br_flag_d  = 1'b0;
            w_mem_ctrl_op_d  = 2'd0;
            w_mem_dst_addr_d = 5'd0;
            w_mem_gpr_wen_d  = 1'b0;
            w_mem_exp_code_d = 3'd0;
            w_mem_out_d      = 32'd0;
        end else if (w_load) begin
            w_mem_pc_d       = ex_pc;
            w_mem_en_d       = ex_en && !r_pend_q;
            w_mem_br_flag_d  = ex_br_flag;
            w_mem_ctrl_op_d  = ex_ctrl_op;
            w_mem_dst_addr_d = ex_dst_addr;
            w_mem_gpr_wen_d  = ex_gpr_wen && !r_pend_q && !w_misalign && !w_res_to;
            if (w_res_to) begin
                w_mem_exp_code_d = c_EXP_TIMEOUT;
            end else if (w_misalign) begin
                w_mem_exp_code_d = c_EXP_MISALIGN;
            end else begin
                w_mem_exp_code_d = ex_exp_code;
            end
            w_mem_out_d      = w_fwd;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state_q        <= c_IDLE;
            r_cnt_q          <= 10'd0;
            r_pend_q         <= 1'b0;
            r_hold_q         <= 1'b0;
            r_hold_data_q    <= 32'd0;
            r_hold_to_q      <= 1'b0;
            r_bus_rw_q       <= 1'b1;
            r_bus_addr_q     <= 30'd0;
            r_bus_wdata_q    <= 32'd0;
            r_mem_pc_q       <= 30'd0;
            r_mem_en_q       <= 1'b0;
            r_mem_br_flag_q  <= 1'b0;
            r_mem_ctrl_op_q  <= 2'd0;
            r_mem_dst_addr_q <= 5'd0;
            r_mem_gpr_wen_q  <= 1'b0;
            r_mem_exp_code_q <= 3'd0;
            r_mem_out_q      <= 32'd0;
        end else begin
            r_state_q        <= w_state_d;
            r_cnt_q          <= w_cnt_d;
            r_pend_q         <= w_pend_d;
            r_hold_q         <= w_hold_d;
            r_hold_data_q    <= w_hold_data_d;
            r_hold_to_q      <= w_hold_to_d;
            r_bus_rw_q       <= w_bus_rw_d;
            r_bus_addr_q     <= w_bus_addr_d;
            r_bus_wdata_q    <= w_bus_wdata_d;
            r_mem_pc_q       <= w_mem_pc_d;
            r_mem_en_q       <= w_mem_en_d;
            r_mem_br_flag_q  <= w_mem_br_flag_d;
            r_mem_ctrl_op_q  <= w_mem_ctrl_op_d;
            r_mem_dst_addr_q <= w_mem_dst_addr_d;
            r_mem_gpr_wen_q  <= w_mem_gpr_wen_d;
            r_mem_exp_code_q <= w_mem_exp_code_d;
            r_mem_out_q      <= w_mem_out_d;
        end
    end

    assign bus_req      = (r_state_q != c_IDLE);
    assign bus_as       = (r_state_q == c_ACCESS);
    assign bus_rw       = r_bus_rw_q;
    assign bus_addr     = r_bus_addr_q;
    assign bus_wdata    = r_bus_wdata_q;
    assign busy         = w_busy;
    assign fwd_data     = w_fwd;
    assign mem_pc       = r_mem_pc_q;
    assign mem_en       = r_mem_en_q;
    assign mem_br_flag  = r_mem_br_flag_q;
    assign mem_ctrl_op  = r_mem_ctrl_op_q;
    assign mem_dst_addr = r_mem_dst_addr_q;
    assign mem_gpr_wen  = r_mem_gpr_wen_q;
    assign mem_exp_code = r_mem_exp_code_q;
    assign mem_out      = r_mem_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_stage
// Desc     : Directed self-checking bench for mem_stage (TIMEOUT_CYC = 8).
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_stage;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        stall, flush;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wdata, ex_out;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_wen;
    logic [2:0]  ex_exp_code;
    logic        bus_req, bus_grant, bus_as, bus_rw, bus_rdy;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        busy;
    logic [31:0] fwd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_wen;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int n_tests  = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int as_cnt   = 0;
    int wc;
    logic to_seen;

    always #5 cpu_clk = ~cpu_clk;

    mem_stage #(.TIMEOUT_CYC(8)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wdata(ex_mem_wdata), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_wen(ex_gpr_wen), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_as(bus_as), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rdy(bus_rdy),
        .busy(busy), .fwd_data(fwd_data), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_wen(mem_gpr_wen), .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic cyc();
        #1;
        if (busy)   busy_cnt++;
        if (bus_as) as_cnt++;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_ex(input logic en, input logic [1:0] op, input logic [31:0] out,
                          input logic [31:0] wd, input logic [4:0] dst, input logic gwen,
                          input logic [2:0] exc, input logic [29:0] pc);
        ex_en        = en;
        ex_mem_op    = op;
        ex_out       = out;
        ex_mem_wdata = wd;
        ex_dst_addr  = dst;
        ex_gpr_wen   = gwen;
        ex_exp_code  = exc;
        ex_pc        = pc;
        ex_br_flag   = en;
        ex_ctrl_op   = 2'd1;
    endtask

    task automatic bubble();
        set_ex(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 3'd0, 30'd0);
        ex_br_flag = 1'b0;
        ex_ctrl_op = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst = 1'b1; stall = 1'b0; flush = 1'b0;
        bus_grant = 1'b0; bus_rdy = 1'b0; bus_rdata = 32'd0;
        bubble();
        repeat (2) @(posedge cpu_clk);
        #1; settle();
        chk("rst_bus_req",  32'(bus_req),  32'd0);
        chk("rst_bus_rw",   32'(bus_rw),   32'd1);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_mem_en",   32'(mem_en),   32'd0);
        chk("rst_mem_out",  mem_out,       32'd0);
        cpu_rst = 1'b0;
        cyc();

        // Aligned load: grant one cycle after request, ready three after
        busy_cnt = 0; as_cnt = 0;
        set_ex(1'b1, 2'd1, 32'h40, 32'd0, 5'd5, 1'b1, 3'd0, 30'h100);
        settle();
        chk("ld_start_busy", 32'(busy), 32'd1);
        chk("ld_start_req",  32'(bus_req), 32'd0);
        cyc();
        settle();
        chk("ld_req", 32'(bus_req), 32'd1);
        cyc();
        bus_grant = 1'b1; settle(); cyc();
        bus_grant = 1'b0; settle();
        chk("ld_as",   32'(bus_as), 32'd1);
        chk("ld_addr", 32'(bus_addr), 32'h10);
        chk("ld_rw",   32'(bus_rw), 32'd1);
        cyc();
        bus_rdy = 1'b1; bus_rdata = 32'hDEADBEEF; settle();
        chk("ld_done_busy", 32'(busy), 32'd0);
        chk("ld_fwd", fwd_data, 32'hDEADBEEF);
        cyc();
        bus_rdy = 1'b0; bus_rdata = 32'd0; bubble(); settle();
        chk("ld_mem_out", mem_out, 32'hDEADBEEF);
        chk("ld_gpr_wen", 32'(mem_gpr_wen), 32'd1);
        chk("ld_mem_en",  32'(mem_en), 32'd1);
        chk("ld_dst",     32'(mem_dst_addr), 32'd5);
        chk("ld_pc",      32'(mem_pc), 32'h100);
        chk("ld_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("ld_as_pulses",   32'(as_cnt), 32'd1);
        cyc();

        // Misaligned store
        set_ex(1'b1, 2'd2, 32'h103, 32'hAA, 5'd3, 1'b1, 3'd0, 30'h101);
        settle();
        chk("mis_busy", 32'(busy), 32'd0);
        chk("mis_req",  32'(bus_req), 32'd0);
        cyc();
        bubble(); settle();
        chk("mis_exp", 32'(mem_exp_code), 32'd4);
        chk("mis_gpr", 32'(mem_gpr_wen), 32'd0);
        chk("mis_req2", 32'(bus_req), 32'd0);
        cyc();

        // Load that never sees bus_rdy
        set_ex(1'b1, 2'd1, 32'h80, 32'd0, 5'd4, 1'b1, 3'd0, 30'h102);
        settle(); cyc();
        bus_grant = 1'b1; settle(); cyc();
        bus_grant = 1'b0; settle();
        chk("to_as", 32'(bus_as), 32'd1);
        cyc();
        wc = 0; to_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            settle();
            wc++;
            if (!busy) begin
                to_seen = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        bubble(); settle();
        chk("to_seen",   32'(to_seen), 32'd1);
        chk("to_cycles", 32'(wc), 32'd8);
        chk("to_req_low", 32'(bus_req), 32'd0);
        chk("to_exp",    32'(mem_exp_code), 32'd6);
        chk("to_gpr",    32'(mem_gpr_wen), 32'd0);
        cyc();

        // Flush pulse while waiting for the bus
        set_ex(1'b1, 2'd1, 32'h44, 32'd0, 5'd6, 1'b1, 3'd0, 30'h103);
        settle(); cyc();
        bus_grant = 1'b1; settle(); cyc();
        bus_grant = 1'b0; settle(); cyc();
        flush = 1'b1; settle();
        chk("fl_busy", 32'(busy), 32'd1);
        cyc();
        flush = 1'b0; bus_rdy = 1'b1; bus_rdata = 32'hCAFEF00D; settle();
        chk("fl_done_busy", 32'(busy), 32'd0);
        cyc();
        bus_rdy = 1'b0;
        set_ex(1'b1, 2'd0, 32'h55, 32'd0, 5'd7, 1'b1, 3'd0, 30'h104);
        settle();
        chk("fl_mem_en",  32'(mem_en), 32'd0);
        chk("fl_gpr",     32'(mem_gpr_wen), 32'd0);
        chk("fl_req_low", 32'(bus_req), 32'd0);
        cyc();
        bubble(); settle();
        chk("alu_en",  32'(mem_en), 32'd1);
        chk("alu_gpr", 32'(mem_gpr_wen), 32'd1);
        chk("alu_out", mem_out, 32'h55);
        chk("alu_dst", 32'(mem_dst_addr), 32'd7);
        cyc();

        // Reset in ACCESS
        set_ex(1'b1, 2'd0, 32'h77, 32'd0, 5'd2, 1'b1, 3'd0, 30'h105);
        settle(); cyc();
        set_ex(1'b1, 2'd1, 32'h60, 32'd0, 5'd2, 1'b1, 3'd0, 30'h106);
        settle(); cyc();
        bus_grant = 1'b1; settle(); cyc();
        bus_grant = 1'b0; settle();
        chk("rs_as_before", 32'(bus_as), 32'd1);
        chk("rs_out_before", mem_out, 32'h77);
        cpu_rst = 1'b1; cyc();
        cpu_rst = 1'b0; bubble(); settle();
        chk("rs_req", 32'(bus_req), 32'd0);
        chk("rs_as",  32'(bus_as), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_out", mem_out, 32'd0);
        chk("rs_en",  32'(mem_en), 32'd0);
        chk("rs_gpr", 32'(mem_gpr_wen), 32'd0);
        chk("rs_pc",  32'(mem_pc), 32'd0);
        cyc();

        // Stall held over the done cycle
        as_cnt = 0;
        set_ex(1'b1, 2'd1, 32'h48, 32'd0, 5'd9, 1'b1, 3'd0, 30'h107);
        settle(); cyc();
        bus_grant = 1'b1; settle(); cyc();
        bus_grant = 1'b0; settle(); cyc();
        bus_rdy = 1'b1; bus_rdata = 32'h12345678; stall = 1'b1; settle(); cyc();
        bus_rdy = 1'b0; bus_rdata = 32'hFFFFFFFF; settle();
        chk("st_out_held", mem_out, 32'd0);
        chk("st_busy",     32'(busy), 32'd0);
        chk("st_req",      32'(bus_req), 32'd0);
        chk("st_fwd",      fwd_data, 32'h12345678);
        cyc();
        settle(); cyc();
        settle();
        chk("st_req2", 32'(bus_req), 32'd0);
        stall = 1'b0; settle();
        chk("st_fwd2", fwd_data, 32'h12345678);
        cyc();
        bubble(); settle();
        chk("st_mem_out", mem_out, 32'h12345678);
        chk("st_en",      32'(mem_en), 32'd1);
        chk("st_gpr",     32'(mem_gpr_wen), 32'd1);
        chk("st_dst",     32'(mem_dst_addr), 32'd9);
        chk("st_as_pulses", 32'(as_cnt), 32'd1);
        cyc();

        // Incoming exception bypasses the bus
        set_ex(1'b1, 2'd1, 32'h50, 32'd0, 5'd1, 1'b1, 3'd2, 30'h108);
        settle();
        chk("exc_busy", 32'(busy), 32'd0);
        chk("exc_req",  32'(bus_req), 32'd0);
        cyc();
        bubble(); settle();
        chk("exc_code", 32'(mem_exp_code), 32'd2);
        chk("exc_req2", 32'(bus_req), 32'd0);
        cyc();

        // Flush of an ALU instruction
        set_ex(1'b1, 2'd0, 32'h99, 32'd0, 5'd3, 1'b1, 3'd0, 30'h109);
        settle(); cyc();
        set_ex(1'b1, 2'd0, 32'hAB, 32'd0, 5'd4, 1'b1, 3'd0, 30'h10A);
        flush = 1'b1; settle();
        chk("fa_prev_out", mem_out, 32'h99);
        cyc();
        flush = 1'b0; bubble(); settle();
        chk("fa_out", mem_out, 32'd0);
        chk("fa_en",  32'(mem_en), 32'd0);
        chk("fa_pc",  32'(mem_pc), 32'd0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
